// File: rtl/jtag_scan_master.sv
// JTAG scan master: turns TAP_RESET / SCAN_IR / SCAN_DR / RUN_IDLE commands into
// TCK/TMS/TDI sequences, two clk cycles per TCK period, and returns the captured TDO bits.
module jtag_scan_master #(
  parameter int MAX_LEN = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [3:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic [2:0]         dbg_state_o
);

  // Handshake: a command is taken on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE/DONE, and rsp_valid is high for exactly the DONE cycle.

  typedef enum logic [2:0] {
    IDLE, RST_SEQ, SEL, SHIFT, EXIT_UPD, RUNCNT, DONE
  } state_t;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b11;
  localparam logic [4:0] MAX_LEN5 = 5'(MAX_LEN);

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [3:0]         len_q, len_d;
  logic               ir_q, ir_d;
  logic               err_q, err_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               lowph_q, lowph_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  state_t             adv_state;
  logic [4:0]         adv_cnt;
  logic [MAX_LEN-1:0] data_sh;
  logic [4:0]         len_ext;
  logic [4:0]         last_bit;
  logic [4:0]         sel_last;
  logic [MAX_LEN-1:0] tdo_word;
  logic               len_bad;

  assign len_ext  = {1'b0, len_q};
  assign last_bit = len_ext - 5'd1;
  assign sel_last = ir_q ? 5'd3 : 5'd2;
  assign tdo_word = {{(MAX_LEN-1){1'b0}}, TDO};
  assign len_bad  = (cmd_len == 4'd0) || ({1'b0, cmd_len} > MAX_LEN5);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      ir_q       <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      cap_q      <= '0;
      lowph_q    <= 1'b0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b1;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ir_q       <= ir_d;
      err_q      <= err_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      lowph_q    <= lowph_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Busy edges alternate: a "rise" edge (lowph_q) raises TCK; a "boundary" edge ends the
  // previous high phase (sampling TDO), steps to the next period, and drives its TMS/TDI.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ir_d       = ir_q;
    err_d      = err_q;
    data_d     = data_q;
    cap_d      = cap_q;
    lowph_d    = lowph_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    adv_state  = state_q;
    adv_cnt    = cnt_q;
    data_sh    = data_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        tck_d   = 1'b0;
        tdi_d   = 1'b1;
        lowph_d = 1'b0;
        if (cmd_valid) begin
          cnt_d  = '0;
          len_d  = cmd_len;
          data_d = cmd_data;
          cap_d  = '0;
          err_d  = 1'b0;
          ir_d   = (cmd_op == OP_IR);
          case (cmd_op)
            OP_RESET: state_d = RST_SEQ;
            OP_RUN:   state_d = RUNCNT;
            default: begin
              // Illegal scan length completes as an empty run with the error flag set.
              if (len_bad) begin
                state_d = RUNCNT;
                len_d   = '0;
                err_d   = 1'b1;
              end else begin
                state_d = SEL;
              end
            end
          endcase
        end
      end

      default: begin
        if (lowph_q) begin
          tck_d   = 1'b1;
          lowph_d = 1'b0;
        end else begin
          // tck_q low here means this is the first boundary after acceptance: nothing to end.
          if (tck_q) begin
            adv_cnt = 5'(cnt_q + 5'd1);
            if (state_q == SHIFT) begin
              cap_d = cap_q | (tdo_word << cnt_q);
            end
            case (state_q)
              RST_SEQ:  if (cnt_q == 5'd5) adv_state = DONE;
              SEL: begin
                if (cnt_q == sel_last) begin
                  adv_state = SHIFT;
                  adv_cnt   = '0;
                end
              end
              SHIFT: begin
                if (cnt_q == last_bit) begin
                  adv_state = EXIT_UPD;
                  adv_cnt   = '0;
                end
              end
              EXIT_UPD: if (cnt_q == 5'd1) adv_state = DONE;
              default:  ;
            endcase
          end
          if ((adv_state == RUNCNT) && (adv_cnt >= len_ext)) begin
            adv_state = DONE;
          end

          state_d = adv_state;
          cnt_d   = adv_cnt;
          tck_d   = 1'b0;
          tdi_d   = 1'b1;
          if (adv_state == DONE) begin
            cnt_d      = '0;
            rsp_data_d = cap_d;
            rsp_err_d  = err_q;
          end else begin
            lowph_d = 1'b1;
            data_sh = data_q >> adv_cnt;
            case (adv_state)
              RST_SEQ:  tms_d = (adv_cnt != 5'd5);
              SEL:      tms_d = ir_q ? (adv_cnt < 5'd2) : (adv_cnt == 5'd0);
              SHIFT: begin
                tms_d = (adv_cnt == last_bit);
                tdi_d = data_sh[0];
              end
              EXIT_UPD: tms_d = (adv_cnt == 5'd0);
              default:  tms_d = 1'b0;
            endcase
          end
        end
      end
    endcase
  end

  assign cmd_ready   = (state_q == IDLE) || (state_q == DONE);
  assign rsp_valid   = (state_q == DONE);
  assign TCK         = tck_q;
  assign TMS         = tms_q;
  assign TDI         = tdi_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural TAP target on the pins, per-command expected
// TMS/TDI sequences, latency and response data derived from the command rules.
module tb_jtag_scan_master;

  localparam int MAX_LEN = 14;
  localparam int TIMEOUT = 100;
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;

  // TAP controller states of the target model
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PAUDR = 6,
                 EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                 PAUIR = 13, EX2IR = 14, UPIR = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd_op = '0;
  logic [3:0]         cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               cmd_ready;
  logic               TCK, TMS, TDI;
  logic               TDO = 1'b0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic [2:0]         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic exp_tms_q[$];
  logic exp_tdi_q[$];
  logic obs_tms_q[$];
  logic obs_tdi_q[$];

  int         tap_st = TLR;
  logic       tap_byp = 1'b0;
  logic [2:0] tap_ir_sr = 3'b000;
  logic [2:0] tap_ir = 3'b111;

  jtag_scan_master #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // target TAP: every instruction selects a 1-bit data register, IR capture value is 3'b001
  function automatic int tap_next(input int s, input logic tms);
    case (s)
      TLR:   return tms ? TLR   : RTI;
      RTI:   return tms ? SELDR : RTI;
      SELDR: return tms ? SELIR : CAPDR;
      CAPDR: return tms ? EX1DR : SHDR;
      SHDR:  return tms ? EX1DR : SHDR;
      EX1DR: return tms ? UPDR  : PAUDR;
      PAUDR: return tms ? EX2DR : PAUDR;
      EX2DR: return tms ? UPDR  : SHDR;
      UPDR:  return tms ? SELDR : RTI;
      SELIR: return tms ? TLR   : CAPIR;
      CAPIR: return tms ? EX1IR : SHIR;
      SHIR:  return tms ? EX1IR : SHIR;
      EX1IR: return tms ? UPIR  : PAUIR;
      PAUIR: return tms ? EX2IR : PAUIR;
      EX2IR: return tms ? UPIR  : SHIR;
      default: return tms ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge TCK) begin
    obs_tms_q.push_back(TMS);
    obs_tdi_q.push_back(TDI);
    if (tap_st == CAPDR) tap_byp <= 1'b0;
    if (tap_st == SHDR)  tap_byp <= TDI;
    if (tap_st == CAPIR) tap_ir_sr <= 3'b001;
    if (tap_st == SHIR)  tap_ir_sr <= {TDI, tap_ir_sr[2:1]};
    tap_st <= tap_next(tap_st, TMS);
  end

  always @(negedge TCK) begin
    if (tap_st == SHDR) TDO <= tap_byp;
    if (tap_st == SHIR) TDO <= tap_ir_sr[0];
    if (tap_st == UPIR) tap_ir <= tap_ir_sr;
    if (tap_st == TLR)  tap_ir <= 3'b111;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [1:0] op, input int len);
    return ((op == OP_IR) || (op == OP_DR)) && ((len == 0) || (len > MAX_LEN));
  endfunction

  function automatic int periods(input logic [1:0] op, input int len);
    if (op == OP_RESET) return 6;
    if (op == OP_RUN) return len;
    if (is_bad(op, len)) return 0;
    return (op == OP_DR) ? len + 5 : len + 6;
  endfunction

  function automatic logic [MAX_LEN-1:0] model_rsp(input logic [1:0] op, input int len,
                                                   input logic [MAX_LEN-1:0] d);
    logic [MAX_LEN-1:0] r;
    logic [2:0] ircap;
    r = '0;
    ircap = 3'b001;
    for (int i = 0; i < len && i < MAX_LEN; i++) begin
      if (op == OP_DR) r[i] = (i == 0) ? 1'b0 : d[i-1];
      else             r[i] = (i < 3) ? ircap[i] : d[i-3];
    end
    return r;
  endfunction

  task automatic build_expect(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] d);
    exp_tms_q.delete();
    exp_tdi_q.delete();
    if (op == OP_RESET) begin
      for (int i = 0; i < 6; i++) begin
        exp_tms_q.push_back(i != 5);
        exp_tdi_q.push_back(1'b1);
      end
    end else if (op == OP_RUN) begin
      for (int i = 0; i < len; i++) begin
        exp_tms_q.push_back(1'b0);
        exp_tdi_q.push_back(1'b1);
      end
    end else if (!is_bad(op, len)) begin
      exp_tms_q.push_back(1'b1);
      if (op == OP_IR) exp_tms_q.push_back(1'b1);
      exp_tms_q.push_back(1'b0);
      exp_tms_q.push_back(1'b0);
      while (exp_tdi_q.size() < exp_tms_q.size()) exp_tdi_q.push_back(1'b1);
      for (int i = 0; i < len; i++) begin
        exp_tms_q.push_back(i == len - 1);
        exp_tdi_q.push_back(d[i]);
      end
      exp_tms_q.push_back(1'b1);
      exp_tms_q.push_back(1'b0);
      exp_tdi_q.push_back(1'b1);
      exp_tdi_q.push_back(1'b1);
    end
  endtask

  function automatic logic [31:0] pack(input logic q[$]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  // driver + scoreboard for one command; hold keeps cmd_valid up (with junk fields) while busy
  task automatic run_cmd(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] d,
                         input bit hold, input string tag);
    int n;
    int cyc;
    bit busy_ok;
    bit bad;
    logic [MAX_LEN-1:0] exp_rsp;
    n = periods(op, len);
    bad = is_bad(op, len);
    exp_rsp = model_rsp(op, len, d);
    build_expect(op, len, d);
    cyc = 0;
    while (!cmd_ready && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ready_in"}, 32'(cmd_ready), 32'd1);
    obs_tms_q.delete();
    obs_tdi_q.delete();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = 4'(len);
    cmd_data  = d;
    @(negedge clk);
    if (hold) begin
      cmd_op   = 2'($urandom_range(0, 3));
      cmd_len  = 4'($urandom_range(0, 15));
      cmd_data = MAX_LEN'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    cyc = 0;
    busy_ok = 1'b1;
    while (!rsp_valid && cyc < TIMEOUT) begin
      if (cmd_ready) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(1 + 2 * n));
    check({tag, "_ready_low_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_ready_at_rsp"}, 32'(cmd_ready), 32'd1);
    check({tag, "_err"}, 32'(rsp_err), 32'(bad));
    check({tag, "_tck_count"}, 32'(obs_tms_q.size()), 32'(n));
    check({tag, "_tms_seq"}, pack(obs_tms_q), pack(exp_tms_q));
    check({tag, "_tdi_seq"}, pack(obs_tdi_q), pack(exp_tdi_q));
    check({tag, "_tap_rti"}, 32'(tap_st), 32'(RTI));
    if ((op == OP_IR || op == OP_DR) && !bad)
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_rsp));
    @(negedge clk);
    check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle_tck_tdi"}, 32'({TCK, TDI}), 32'b01);
    if ((op == OP_IR || op == OP_DR) && !bad) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      check({tag, "_rsp_hold"}, 32'(rsp_data), 32'(exp_rsp));
    end
  endtask

  initial begin
    bit seen;
    logic [MAX_LEN-1:0] dr_pat;
    dr_pat = 14'b01001101010100;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tck", 32'(TCK), 32'd0);
    check("rst_tms", 32'(TMS), 32'd1);
    check("rst_tdi", 32'(TDI), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed commands
    run_cmd(OP_RESET, 0, '0, 1'b0, "tap_reset");
    run_cmd(OP_DR, 14, dr_pat, 1'b0, "dr14_bypass");
    check("dr14_const", 32'(rsp_data), 32'(14'b10011010101000));
    run_cmd(OP_IR, 3, 14'b011, 1'b0, "ir3_intest");
    check("ir3_const", 32'(rsp_data), 32'(3'b001));
    check("ir3_tap_ir", 32'(tap_ir), 32'(3'b011));
    run_cmd(OP_DR, 0, 14'h3fff, 1'b0, "dr_len0");
    run_cmd(OP_DR, 15, 14'h1234, 1'b0, "dr_len15");
    run_cmd(OP_IR, 1, 14'h1, 1'b0, "ir_len1");
    run_cmd(OP_RUN, 0, '0, 1'b0, "run0");
    run_cmd(OP_RUN, 7, '0, 1'b0, "run7");
    run_cmd(OP_DR, 5, 14'h15, 1'b1, "busy_hold");

    // abort mid-shift
    obs_tms_q.delete();
    obs_tdi_q.delete();
    cmd_valid = 1'b1;
    cmd_op    = OP_DR;
    cmd_len   = 4'd14;
    cmd_data  = MAX_LEN'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_progress", 32'(obs_tms_q.size()), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tck", 32'(TCK), 32'd0);
    check("abort_tms", 32'(TMS), 32'd1);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    run_cmd(OP_RESET, 0, '0, 1'b0, "post_abort_reset");

    // randomized commands
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op;
      int len;
      logic [MAX_LEN-1:0] d;
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 15);
      if ((op == OP_IR || op == OP_DR) && $urandom_range(0, 3) != 0)
        len = $urandom_range(1, MAX_LEN);
      d = MAX_LEN'($urandom);
      run_cmd(op, len, d, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
